// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: valid/ready on both sides, flush, registered ready.
// Optional PIPE_SKID_NOP_INJECT_EN drives NOP_VALUE on out_data during bubbles.
module pipe_skid_reg #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] NOP_VALUE   = WIDTH'(32'h00000013)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // state | meaning
   // EMPTY | no entries held
   // HALF  | main register holds the head entry
   // FULL  | main holds head, skid holds the next entry
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = RESET_VALUE;
         skid_d  = RESET_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = HALF;
                  main_d  = in_data;
               end
            end
            HALF: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a drain can happen
               if (out_fire) begin
                  state_d = HALF;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         EMPTY: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
         HALF: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

`ifdef PIPE_SKID_NOP_INJECT_EN
   assign out_data = out_valid ? main_q : NOP_VALUE;
`else
   logic unused_nop_value;
   assign unused_nop_value = ^NOP_VALUE;
   assign out_data = main_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random-handshake bench for pipe_skid_reg (32-bit, RESET_VALUE=0).
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   pipe_skid_reg #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bubble(input logic [31:0] stale);
`ifdef PIPE_SKID_NOP_INJECT_EN
      return 32'h00000013;
`else
      return stale;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic rdy, input logic vld,
                            input logic [1:0] occ, input logic [31:0] dat);
      chk({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
      chk({tag, ".out_data"},  out_data,       dat);
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_data  = 'x;
   endtask

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] next_data;
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        ifire, ofire;

      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      idle_in();

      // reset held for two cycles
      step();
      step();
      chk_state("reset", 1'b1, 1'b0, 2'd0, bubble(32'h0));
      rst = 1'b1;
      step();
      chk_state("post_reset", 1'b1, 1'b0, 2'd0, bubble(32'h0));

      // streaming at one transfer per cycle
      out_ready = 1'b1;
      send(32'h11); step(); chk_state("stream_11", 1'b1, 1'b1, 2'd1, 32'h11);
      send(32'h22); step(); chk_state("stream_22", 1'b1, 1'b1, 2'd1, 32'h22);
      send(32'h33); step(); chk_state("stream_33", 1'b1, 1'b1, 2'd1, 32'h33);
      idle_in();    step(); chk_state("stream_drain", 1'b1, 1'b0, 2'd0, bubble(32'h33));

      // back-pressure to FULL, then drain
      out_ready = 1'b0;
      send(32'hA1); step(); chk_state("bp_a1", 1'b1, 1'b1, 2'd1, 32'hA1);
      send(32'hA2); step(); chk_state("bp_full", 1'b0, 1'b1, 2'd2, 32'hA1);
      send(32'hAF); step(); chk_state("bp_hold", 1'b0, 1'b1, 2'd2, 32'hA1);
      idle_in();
      out_ready = 1'b1;
      step(); chk_state("bp_out_a2", 1'b1, 1'b1, 2'd1, 32'hA2);
      step(); chk_state("bp_empty", 1'b1, 1'b0, 2'd0, bubble(32'hA2));

      // flush while FULL with a simultaneous input
      out_ready = 1'b0;
      send(32'hB1); step();
      send(32'hB2); step(); chk_state("fl_full", 1'b0, 1'b1, 2'd2, 32'hB1);
      flush = 1'b1;
      out_ready = 1'b1;
      send(32'hB3); step(); chk_state("fl_flushed", 1'b1, 1'b0, 2'd0, bubble(32'h0));
      flush = 1'b0;
      idle_in();    step(); chk_state("fl_no_b3", 1'b1, 1'b0, 2'd0, bubble(32'h0));

      // asynchronous reset between edges
      out_ready = 1'b0;
      send(32'hC1); step(); chk_state("ar_half", 1'b1, 1'b1, 2'd1, 32'hC1);
      idle_in();
      #2 rst = 1'b0;
      #1 chk_state("ar_async", 1'b1, 1'b0, 2'd0, bubble(32'h0));
      step();
      rst = 1'b1;
      step();
      chk_state("ar_release", 1'b1, 1'b0, 2'd0, bubble(32'h0));

      // random handshake soak against a FIFO reference
      next_data  = 32'h1000;
      prev_stall = 1'b0;
      prev_data  = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 3) != 0) send(next_data);
         else idle_in();
         out_ready = ($urandom_range(0, 2) != 0);
         #0;
         chk("soak.occupancy", 32'(occupancy), 32'(exp_q.size()));
         if (prev_stall) begin
            chk("soak.stall_valid", 32'(out_valid), 32'h1);
            chk("soak.stall_data", out_data, prev_data);
         end
         if (out_valid && exp_q.size() != 0)
            chk("soak.order", out_data, exp_q[0]);
         ifire = in_valid && in_ready;
         ofire = out_valid && out_ready;
         if (ofire && exp_q.size() != 0) void'(exp_q.pop_front());
         if (ifire) begin
            exp_q.push_back(next_data);
            next_data++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         step();
      end

      idle_in();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (out_valid && exp_q.size() != 0) begin
            chk("drain.order", out_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
         step();
      end
      chk("drain.empty", 32'(occupancy), 32'(exp_q.size()));
      chk("drain.valid", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
